// File: rtl/global_defs.sv
// rtl/global_defs.sv - shared DRAM command types, timing defaults and address map
package global_defs;

    localparam int ADDR_W = 36;

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } dram_cmd_t;

    // Encoding 2'd3 is reserved and treated as an unknown opcode.
    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2
    } opcode_t;

    typedef struct packed {
        opcode_t             opcode;
        logic [ADDR_W-1:0]   address;
        logic [31:0]         time_cpu;
    } parser_out_struct_t;

    localparam int DEF_T_RCD   = 24;
    localparam int DEF_T_RAS   = 52;
    localparam int DEF_T_RP    = 24;
    localparam int DEF_T_CL    = 24;
    localparam int DEF_T_CWL   = 20;
    localparam int DEF_T_BURST = 4;
    localparam int DEF_T_WR    = 20;

    // Address map: row | bg | bank | col, column in the low bits.
    localparam int                COL_OFFSET  = 0;
    localparam logic [ADDR_W-1:0] COL_MASK    = 36'h0_0000_03FF;
    localparam int                BANK_OFFSET = 10;
    localparam logic [ADDR_W-1:0] BANK_MASK   = 36'h0_0000_0003;
    localparam int                BG_OFFSET   = 12;
    localparam logic [ADDR_W-1:0] BG_MASK     = 36'h0_0000_0003;
    localparam int                ROW_OFFSET  = 14;
    localparam logic [ADDR_W-1:0] ROW_MASK    = 36'h0_0000_FFFF;

    function automatic logic opcode_known(input opcode_t op);
        return (op == OP_READ) || (op == OP_WRITE) || (op == OP_IFETCH);
    endfunction

endpackage

// File: rtl/dram_cmd_sched.sv
// rtl/dram_cmd_sched.sv - single-bank ACT/RD/WR/PRE scheduler, optional trace via DRAM_CMD_TRACE_EN
module dram_cmd_sched
    import global_defs::*;
#(
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_RAS   = DEF_T_RAS,
    parameter int T_RP    = DEF_T_RP,
    parameter int T_CL    = DEF_T_CL,
    parameter int T_CWL   = DEF_T_CWL,
    parameter int T_BURST = DEF_T_BURST,
    parameter int T_WR    = DEF_T_WR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  parser_out_struct_t req,
    output logic               req_ready,
    output logic               cmd_valid,
    output dram_cmd_t          cmd,
    output logic [1:0]         cmd_bg,
    output logic [1:0]         cmd_bank,
    output logic [15:0]        cmd_row,
    output logic [9:0]         cmd_col,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_WAIT_RCD, S_RDWR, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    // Cycles spent in each wait state: the command after the wait lands
    // exactly N+1 cycles after the command before it. A zero wait skips the state.
    localparam int RD_SPAN = ((T_RAS - T_RCD) > (T_CL + T_BURST)) ?
                             (T_RAS - T_RCD) : (T_CL + T_BURST);
    localparam int WR_SPAN = ((T_RAS - T_RCD) > (T_CWL + T_BURST + T_WR)) ?
                             (T_RAS - T_RCD) : (T_CWL + T_BURST + T_WR);
    localparam int RCD_WAIT    = T_RCD - 1;
    localparam int RD_PRE_WAIT = RD_SPAN - 1;
    localparam int WR_PRE_WAIT = WR_SPAN - 1;
    localparam int RP_WAIT     = T_RP - 1;

    localparam bit PARAMS_OK =
        (T_RCD   >= 1) && (T_RCD   <= 255) && (T_RAS >= 1) && (T_RAS <= 255) &&
        (T_RP    >= 1) && (T_RP    <= 255) && (T_CL  >= 1) && (T_CL  <= 255) &&
        (T_CWL   >= 1) && (T_CWL   <= 255) && (T_WR  >= 1) && (T_WR  <= 255) &&
        (T_BURST >= 1) && (T_BURST <= 255);
    localparam bit WAITS_FIT = (RD_PRE_WAIT <= 255) && (WR_PRE_WAIT <= 255);

    if (!PARAMS_OK) begin : g_bad_timing
        $error("dram_cmd_sched: every timing parameter must be in 1..255");
    end
    if (!WAITS_FIT) begin : g_bad_span
        $error("dram_cmd_sched: RD/WR-to-PRE wait does not fit the 8-bit counter");
    end

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  bg_q, bg_d;
    logic [1:0]  bank_q, bank_d;
    logic [15:0] row_q, row_d;
    logic [9:0]  col_q, col_d;

    logic        accept;
    logic        unused_time;

    assign unused_time = ^req.time_cpu;
    assign req_ready   = (state_q == S_IDLE) && rst_n;
    assign accept      = req_valid && req_ready && opcode_known(req.opcode);
    assign busy        = (state_q != S_IDLE);
    assign cmd_bg      = bg_q;
    assign cmd_bank    = bank_q;
    assign cmd_row     = row_q;

    // Next-state, counter, address latch and command decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        bg_d      = bg_q;
        bank_d    = bank_q;
        row_d     = row_q;
        col_d     = col_q;
        cmd_valid = 1'b0;
        cmd       = CMD_PRE;
        cmd_col   = 10'd0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACT;
                    is_wr_d = (req.opcode == OP_WRITE);
                    col_d   = 10'((req.address >> COL_OFFSET)  & COL_MASK);
                    bank_d  = 2'((req.address  >> BANK_OFFSET) & BANK_MASK);
                    bg_d    = 2'((req.address  >> BG_OFFSET)   & BG_MASK);
                    row_d   = 16'((req.address >> ROW_OFFSET)  & ROW_MASK);
                end
            end
            S_ACT: begin
                cmd_valid = 1'b1;
                cmd       = CMD_ACT;
                cnt_d     = 8'(RCD_WAIT);
                state_d   = (RCD_WAIT == 0) ? S_RDWR : S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = S_RDWR;
            end
            S_RDWR: begin
                cmd_valid = 1'b1;
                cmd       = is_wr_q ? CMD_WR : CMD_RD;
                cmd_col   = col_q;
                cnt_d     = is_wr_q ? 8'(WR_PRE_WAIT) : 8'(RD_PRE_WAIT);
                state_d   = S_WAIT_PRE;
            end
            S_WAIT_PRE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = S_PRE;
            end
            S_PRE: begin
                cmd_valid = 1'b1;
                cmd       = CMD_PRE;
                bg_d      = 2'd0;
                bank_d    = 2'd0;
                row_d     = 16'd0;
                col_d     = 10'd0;
                cnt_d     = 8'(RP_WAIT);
                state_d   = (RP_WAIT == 0) ? S_IDLE : S_WAIT_RP;
            end
            S_WAIT_RP: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and latched request fields; reset abandons any open access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            is_wr_q <= 1'b0;
            bg_q    <= 2'd0;
            bank_q  <= 2'd0;
            row_q   <= 16'd0;
            col_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            bg_q    <= bg_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Flag an offered request whose opcode the scheduler cannot serve
    always_ff @(posedge clk) begin
        if (rst_n && req_valid && req_ready) begin
            assert (opcode_known(req.opcode))
            else $error("dram_cmd_sched: unknown opcode %0d left unaccepted", req.opcode);
        end
    end

`ifdef DRAM_CMD_TRACE_EN
    logic [31:0] trace_cyc_q, trace_cyc_d;

    assign trace_cyc_d = trace_cyc_q + 32'd1;

    // Cycle stamp and one trace line per issued command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_cyc_q <= 32'd0;
        end else begin
            trace_cyc_q <= trace_cyc_d;
            if (cmd_valid) begin
                $display("%0h %s %h %h %h|%h", trace_cyc_q, cmd.name(),
                         cmd_bg, cmd_bank, cmd_row, cmd_col);
            end
        end
    end
`else
    // Trace disabled: no extra state and no simulation output.
`endif

endmodule

// File: tb/tb_dram_cmd_sched.sv
// tb/tb_dram_cmd_sched.sv - directed self-checking bench for dram_cmd_sched
module tb_dram_cmd_sched;
    import global_defs::*;

    typedef struct {
        int          cyc;
        dram_cmd_t   c;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } rec_t;

    localparam logic [35:0] ADDR0 = 36'h0_0001_2345;
    localparam logic [35:0] ADDR1 = 36'h0_ABCD_7C21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               req_valid, req_ready, cmd_valid, busy;
    parser_out_struct_t req;
    dram_cmd_t          cmd;
    logic [1:0]         cmd_bg, cmd_bank;
    logic [15:0]        cmd_row;
    logic [9:0]         cmd_col;

    logic               req_valid_r, req_ready_r, cmd_valid_r, busy_r;
    parser_out_struct_t req_r;
    dram_cmd_t          cmd_r;
    logic [1:0]         cmd_bg_r, cmd_bank_r;
    logic [15:0]        cmd_row_r;
    logic [9:0]         cmd_col_r;

    dram_cmd_sched dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req(req),
        .req_ready(req_ready), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .busy(busy)
    );

    dram_cmd_sched #(.T_RAS(80)) dut_ras (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_r), .req(req_r),
        .req_ready(req_ready_r), .cmd_valid(cmd_valid_r), .cmd(cmd_r),
        .cmd_bg(cmd_bg_r), .cmd_bank(cmd_bank_r), .cmd_row(cmd_row_r),
        .cmd_col(cmd_col_r), .busy(busy_r)
    );

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    rec_t log_q[$];
    rec_t log_r[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid)   log_q.push_back('{cyc, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col});
        if (cmd_valid_r) log_r.push_back('{cyc, cmd_r, cmd_bg_r, cmd_bank_r, cmd_row_r, cmd_col_r});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t get_rec(input rec_t q[$], input int i);
        rec_t r;
        r = '{-1, CMD_PRE, 2'd0, 2'd0, 16'd0, 10'd0};
        if (i < q.size()) r = q[i];
        return r;
    endfunction

    task automatic check_rec(input string tag, input rec_t r, input int a, input int rel,
                             input dram_cmd_t c, input logic [1:0] bg, input logic [1:0] bank,
                             input logic [15:0] row, input logic [9:0] col);
        check({tag, "_cyc"}, 64'(r.cyc - a), 64'(rel));
        check({tag, "_cmd"}, 64'(r.c), 64'(c));
        check({tag, "_bg"}, 64'(r.bg), 64'(bg));
        check({tag, "_bank"}, 64'(r.bank), 64'(bank));
        check({tag, "_row"}, 64'(r.row), 64'(row));
        check({tag, "_col"}, 64'(r.col), 64'(col));
    endtask

    task automatic send(input opcode_t op, input logic [35:0] ad, output int a);
        @(negedge clk); #1;
        a = cyc + 1;
        req_valid = 1'b1;
        req = '{op, ad, 32'h1234};
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit use_r, output int rc);
        rc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (!use_r && req_ready && !busy) begin rc = cyc; break; end
            if (use_r && req_ready_r && !busy_r) begin rc = cyc; break; end
        end
        if (rc < 0) check("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int a, rc, x;
        rec_t r;
        req_valid = 1'b0;
        req = '{OP_READ, 36'd0, 32'd0};
        req_valid_r = 1'b0;
        req_r = '{OP_READ, 36'd0, 32'd0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd", 64'(cmd), 64'(CMD_PRE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_row", 64'(cmd_row), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_ready", 64'(req_ready), 64'd1);

        // Read: ACT@0, RD@24, PRE@52, ready@76
        log_q.delete();
        send(OP_READ, ADDR0, a);
        check("rd_busy", 64'(busy), 64'd1);
        check("rd_not_ready", 64'(req_ready), 64'd0);
        wait_idle(1'b0, rc);
        check("rd_ready_at", 64'(rc - a), 64'd76);
        check("rd_ncmd", 64'(log_q.size()), 64'd3);
        check_rec("rd_act", get_rec(log_q, 0), a, 0,  CMD_ACT, 2'd2, 2'd0, 16'h0004, 10'h000);
        check_rec("rd_rd",  get_rec(log_q, 1), a, 24, CMD_RD,  2'd2, 2'd0, 16'h0004, 10'h345);
        check_rec("rd_pre", get_rec(log_q, 2), a, 52, CMD_PRE, 2'd2, 2'd0, 16'h0004, 10'h000);

        // Write: ACT@0, WR@24, PRE@68, ready@92
        log_q.delete();
        send(OP_WRITE, ADDR0, a);
        wait_idle(1'b0, rc);
        check("wr_ready_at", 64'(rc - a), 64'd92);
        check("wr_ncmd", 64'(log_q.size()), 64'd3);
        check_rec("wr_act", get_rec(log_q, 0), a, 0,  CMD_ACT, 2'd2, 2'd0, 16'h0004, 10'h000);
        check_rec("wr_wr",  get_rec(log_q, 1), a, 24, CMD_WR,  2'd2, 2'd0, 16'h0004, 10'h345);
        check_rec("wr_pre", get_rec(log_q, 2), a, 68, CMD_PRE, 2'd2, 2'd0, 16'h0004, 10'h000);

        // Instruction fetch at a different address: read timing
        log_q.delete();
        send(OP_IFETCH, ADDR1, a);
        wait_idle(1'b0, rc);
        check("if_ready_at", 64'(rc - a), 64'd76);
        check("if_ncmd", 64'(log_q.size()), 64'd3);
        check_rec("if_act", get_rec(log_q, 0), a, 0,  CMD_ACT, 2'd3, 2'd3, 16'hAF35, 10'h000);
        check_rec("if_rd",  get_rec(log_q, 1), a, 24, CMD_RD,  2'd3, 2'd3, 16'hAF35, 10'h021);
        check_rec("if_pre", get_rec(log_q, 2), a, 52, CMD_PRE, 2'd3, 2'd3, 16'hAF35, 10'h000);

        // Back-to-back reads with req_valid held high
        log_q.delete();
        @(negedge clk); #1;
        x = cyc;
        a = x + 1;
        req_valid = 1'b1;
        req = '{OP_READ, ADDR0, 32'h5};
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (log_q.size() >= 4) break;
        end
        req_valid = 1'b0;
        wait_idle(1'b0, rc);
        check("b2b_ready_at", 64'(rc - a), 64'd153);
        check("b2b_ncmd", 64'(log_q.size()), 64'd6);
        r = get_rec(log_q, 2);
        check("b2b_pre1_cyc", 64'(r.cyc - a), 64'd52);
        r = get_rec(log_q, 3);
        check("b2b_act2_cyc", 64'(r.cyc - a), 64'd77);
        check("b2b_act2_cmd", 64'(r.c), 64'(CMD_ACT));
        r = get_rec(log_q, 4);
        check("b2b_rd2_cyc", 64'(r.cyc - a), 64'd101);
        r = get_rec(log_q, 5);
        check("b2b_pre2_cyc", 64'(r.cyc - a), 64'd129);
        check("b2b_pre2_cmd", 64'(r.c), 64'(CMD_PRE));

        // Reset mid-write at A+30: outputs clear at once, no PRE afterwards
        log_q.delete();
        send(OP_WRITE, ADDR0, a);
        for (int i = 0; i < 100; i++) begin
            if (cyc >= a + 30) break;
            @(negedge clk); #1;
        end
        check("mid_rst_cycle", 64'(cyc - a), 64'd30);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("mid_rst_cmd", 64'(cmd), 64'(CMD_PRE));
        check("mid_rst_bg", 64'(cmd_bg), 64'd0);
        check("mid_rst_bank", 64'(cmd_bank), 64'd0);
        check("mid_rst_row", 64'(cmd_row), 64'd0);
        check("mid_rst_col", 64'(cmd_col), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        repeat (120) @(negedge clk);
        #1;
        check("mid_rst_ncmd", 64'(log_q.size()), 64'd2);
        r = get_rec(log_q, 1);
        check("mid_rst_last_cmd", 64'(r.c), 64'(CMD_WR));

        // T_RAS=80 read: PRE at A+80, ready at A+104
        log_r.delete();
        @(negedge clk); #1;
        a = cyc + 1;
        req_valid_r = 1'b1;
        req_r = '{OP_READ, ADDR0, 32'h9};
        @(negedge clk); #1;
        req_valid_r = 1'b0;
        wait_idle(1'b1, rc);
        check("ras_ready_at", 64'(rc - a), 64'd104);
        check("ras_ncmd", 64'(log_r.size()), 64'd3);
        check_rec("ras_act", get_rec(log_r, 0), a, 0,  CMD_ACT, 2'd2, 2'd0, 16'h0004, 10'h000);
        check_rec("ras_rd",  get_rec(log_r, 1), a, 24, CMD_RD,  2'd2, 2'd0, 16'h0004, 10'h345);
        check_rec("ras_pre", get_rec(log_r, 2), a, 80, CMD_PRE, 2'd2, 2'd0, 16'h0004, 10'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dram_cmd_sched.md
DRAM_CMD_SCHED -- requirements
Module: dram_cmd_sched

Interface
REQ-001 SHALL have parameter T_RCD, default 24: ACT-to-RD/WR delay, in clk cycles.
REQ-002 SHALL have parameter T_RAS, default 52: minimum ACT-to-PRE delay, in clk cycles.
REQ-003 SHALL have parameter T_RP, default 24: PRE-to-next-ACT delay, in clk cycles.
REQ-004 SHALL have parameter T_CL, default 24: RD-to-data delay, in clk cycles.
REQ-005 SHALL have parameter T_CWL, default 20: WR-to-data delay, in clk cycles.
REQ-006 SHALL have parameter T_BURST, default 4: data burst length, in clk cycles.
REQ-007 SHALL have parameter T_WR, default 20: write recovery after burst, in clk cycles.
REQ-008 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  popped queue request is valid.
- req  in  parser_out_struct_t  request (opcode, address, time_cpu).
- req_ready  out  1  scheduler can accept a request.
- cmd_valid  out  1  a DRAM command is issued this cycle.
- cmd  out  dram_cmd_t  command code: ACT, RD, WR, PRE.
- cmd_bg  out  2  bank group.
- cmd_bank  out  2  bank.
- cmd_row  out  16  row.
- cmd_col  out  10  column.
- busy  out  1  state is not IDLE.

Function
REQ-009 SHALL accept a request on a rising edge where req_valid && req_ready; req_ready SHALL be 1 only in IDLE.
REQ-010 SHALL decode bg/bank/row/col from req.address using the package masks and offsets, and hold the decoded fields until the request's PRE has issued.
REQ-011 SHALL run the FSM IDLE -> ACT -> WAIT_RCD -> RDWR -> WAIT_PRE -> PRE -> WAIT_RP -> IDLE.
REQ-012 SHALL issue ACT (cmd_valid=1) in the cycle following acceptance; call this cycle A.
REQ-013 SHALL issue RD for opcode data-read or instruction-fetch, and WR for opcode write, in cycle A+T_RCD.
REQ-014 SHALL issue PRE at:
- read: cycle max(A+T_RAS, A+T_RCD+T_CL+T_BURST).
- write: cycle max(A+T_RAS, A+T_RCD+T_CWL+T_BURST+T_WR).
REQ-015 SHALL return to IDLE (req_ready=1) in cycle PRE+T_RP.
REQ-016 SHALL hold cmd_valid for exactly one cycle per command, and hold it at 0 in every other cycle.
REQ-017 SHALL drive cmd_col only with RD/WR; it SHALL be 0 with ACT and PRE.
REQ-018 SHALL ignore req_valid while req_ready=0; the upstream block holds req stable until it is accepted.
REQ-019 SHALL use a single 8-bit down-counter for all waits; every timing parameter SHALL be in 1..255, enforced by elaboration-time assertion.
REQ-020 SHALL leave an unknown opcode unaccepted: it is flagged by a simulation assertion error and req_ready stays 1.

Reset
REQ-021 SHALL, on rst_n=0 (including mid-operation), immediately force:
- state to IDLE;
- cmd_valid=0, cmd=PRE, and all address outputs 0;
- counter to 0, busy=0, req_ready=1 once rst_n=1.
No PRE is issued for an aborted access.

Configuration
REQ-022 SHALL, when DRAM_CMD_TRACE_EN is defined, $display every issued command as "<cycle> <CMD> bg bank row|col" in hex.
REQ-023 SHALL produce no output when DRAM_CMD_TRACE_EN is undefined; RTL behaviour is identical in both cases.

Structure
REQ-024 SHALL place dram_cmd_t, the timing defaults, and the address masks/offsets in global_defs; parser_out_struct_t comes from there too.
REQ-025 SHALL be a single module; the counter is inline, with no sub-module.

Verification
REQ-026 Read 0x0_0001_2345 accepted, A=10 -> ACT@10, RD@34, PRE@62, req_ready@86.
REQ-027 Write to the same address, A=10 -> ACT@10, WR@34, PRE@78, req_ready@102.
REQ-028 Ifetch -> identical timing to read; cmd=RD.
REQ-029 req_valid held high across two reads -> second ACT exactly 1 cycle after req_ready rises; no command issued while busy.
REQ-030 rst_n pulsed low at A+30 of a write -> outputs zero immediately; no PRE issued; req_ready=1 after release.
REQ-031 T_RAS=80 read -> PRE@A+80, overriding the data-path bound.
